// File: rtl/shift_pkg.sv
// Types shared by the shift register and its command sequencer.
package shift_pkg;

  typedef enum logic [1:0] {
    NA    = 2'b00,
    LOAD  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } funct_t;

  // State literals are prefixed so they do not collide with the funct_t literals in this scope.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_SHIFT = 2'b10,
    S_DONE  = 2'b11
  } seq_state_t;

endpackage : shift_pkg

// File: rtl/shift_seq.sv
// Command sequencer for the downstream shift register: one LOAD followed by WIDTH shifts per command,
// with a shadow copy of the register so the exiting bit can be presented as a serial stream.
module shift_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [WIDTH-1:0] cmd_word_i,
  input  logic             cmd_dir_i,
  input  logic             cmd_fill_i,
  input  logic             abort_i,
  output funct_t           funct_o,
  output logic [WIDTH-1:0] word_o,
  output logic             serial_o,
  output logic             bit_o,
  output logic             bit_valid_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CNT_W = $clog2(WIDTH);

  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] shadow;
  logic             dir_q;
  logic             fill_q;
  logic             last_shift;

  assign last_shift = (cnt == CNT_W'(WIDTH - 1));

  // NOTE: state registers use non-blocking assignments only, so every flop samples
  // pre-edge values regardless of statement order inside the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      word_q <= '0;
      shadow <= '0;
      dir_q  <= 1'b0;
      fill_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // cmd_ready_o is exactly (state == S_IDLE), so valid alone completes the handshake here.
          if (cmd_valid_i) begin
            word_q <= cmd_word_i;
            dir_q  <= cmd_dir_i;
            fill_q <= cmd_fill_i;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          shadow <= word_q;
          cnt    <= '0;
          state  <= abort_i ? S_IDLE : S_SHIFT;
        end
        S_SHIFT: begin
          // Shadow tracks the downstream register exactly, including the shift in an aborted cycle.
          if (dir_q) shadow <= {fill_q, shadow[WIDTH-1:1]};
          else       shadow <= {shadow[WIDTH-2:0], fill_q};
          if (!last_shift) cnt <= cnt + 1'b1;
          if (abort_i)         state <= S_IDLE;
          else if (last_shift) state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // NOTE: funct_o gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    funct_o = NA;
    case (state)
      S_LOAD:  funct_o = LOAD;
      S_SHIFT: funct_o = dir_q ? RIGHT : LEFT;
      default: funct_o = NA;
    endcase
  end

  assign cmd_ready_o = (state == S_IDLE);
  assign busy_o      = (state == S_LOAD) || (state == S_SHIFT);
  assign done_o      = (state == S_DONE);
  assign word_o      = word_q;
  assign serial_o    = (state == S_SHIFT) && fill_q;
  assign bit_valid_o = (state == S_SHIFT);
  assign bit_o       = (state == S_SHIFT) && (dir_q ? shadow[0] : shadow[WIDTH-1]);

endmodule : shift_seq

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq: scoreboard of expected serial bits plus a behavioural downstream register.
module tb_shift_seq;
  import shift_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid_i;
  logic         cmd_ready_o;
  logic [W-1:0] cmd_word_i;
  logic         cmd_dir_i;
  logic         cmd_fill_i;
  logic         abort_i;
  funct_t       funct_o;
  logic [W-1:0] word_o;
  logic         serial_o;
  logic         bit_o;
  logic         bit_valid_o;
  logic         busy_o;
  logic         done_o;

  shift_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_word_i  (cmd_word_i),
    .cmd_dir_i   (cmd_dir_i),
    .cmd_fill_i  (cmd_fill_i),
    .abort_i     (abort_i),
    .funct_o     (funct_o),
    .word_o      (word_o),
    .serial_o    (serial_o),
    .bit_o       (bit_o),
    .bit_valid_o (bit_valid_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  // Behavioural model of the downstream shift register, driven only by the sequencer outputs.
  logic [W-1:0] ds;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ds <= '0;
    else begin
      case (funct_o)
        LOAD:    ds <= word_o;
        LEFT:    ds <= {ds[W-2:0], serial_o};
        RIGHT:   ds <= {serial_o, ds[W-1:1]};
        default: ds <= ds;
      endcase
    end
  end

  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   done_cnt = 0;
  logic exp_bits[$];
  int   accepts[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: detect handshakes, push expected bits on accept, pop and compare emitted bits.
  task automatic tick();
    logic         acc;
    logic [W-1:0] w;
    logic         d;
    int           sz;
    acc = rst_n && cmd_valid_i && cmd_ready_o;
    w   = cmd_word_i;
    d   = cmd_dir_i;
    @(posedge clk);
    #1;
    cycle++;
    if (acc) begin
      accepts.push_back(cycle);
      for (int i = 0; i < W; i++) exp_bits.push_back(d ? w[i] : w[W-1-i]);
    end
    if (done_o) done_cnt++;
    if (bit_valid_o) begin
      sz = exp_bits.size();
      check("bit_queue_nonempty", sz > 0, 1);
      if (sz > 0) check("bit_o", bit_o, exp_bits.pop_front());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, cmd_ready_o, 1);
    check({tag, "_funct"}, funct_o, NA);
    check({tag, "_word"}, word_o, 0);
    check({tag, "_serial"}, serial_o, 0);
    check({tag, "_bit"}, bit_o, 0);
    check({tag, "_bit_valid"}, bit_valid_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
  endtask

  int d0;
  int busy_cnt;
  int n0;

  initial begin
    rst_n       = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_word_i  = '0;
    cmd_dir_i   = 1'b0;
    cmd_fill_i  = 1'b0;
    abort_i     = 1'b0;
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1) 1011 LEFT fill 0
    d0 = done_cnt;
    cmd_valid_i = 1'b1; cmd_word_i = 4'b1011; cmd_dir_i = 1'b0; cmd_fill_i = 1'b0;
    tick();
    cmd_valid_i = 1'b0;
    check("t1_load_funct", funct_o, LOAD);
    check("t1_load_word", word_o, 4'b1011);
    check("t1_load_ready", cmd_ready_o, 0);
    check("t1_load_busy", busy_o, 1);
    for (int i = 0; i < W; i++) begin
      tick();
      check("t1_shift_funct", funct_o, LEFT);
      check("t1_shift_serial", serial_o, 0);
      check("t1_shift_busy", busy_o, 1);
    end
    tick();
    check("t1_done", done_o, 1);
    check("t1_done_funct", funct_o, NA);
    check("t1_done_ready", cmd_ready_o, 0);
    check("t1_done_busy", busy_o, 0);
    check("t1_ds", ds, 4'b0000);
    tick();
    check("t1_idle_done", done_o, 0);
    check("t1_idle_ready", cmd_ready_o, 1);
    check("t1_done_pulses", done_cnt - d0, 1);
    check("t1_queue_empty", exp_bits.size(), 0);

    // 2) 1011 RIGHT fill 1
    busy_cnt = 0;
    cmd_valid_i = 1'b1; cmd_word_i = 4'b1011; cmd_dir_i = 1'b1; cmd_fill_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      cmd_valid_i = 1'b0;
      if (funct_o == RIGHT) check("t2_serial", serial_o, 1);
      if (busy_o) busy_cnt++;
    end
    check("t2_busy_cycles", busy_cnt, 5);
    check("t2_ds", ds, 4'b1111);
    check("t2_queue_empty", exp_bits.size(), 0);

    // 3) valid held high across two back-to-back commands
    n0 = accepts.size();
    cmd_valid_i = 1'b1; cmd_word_i = 4'hA; cmd_dir_i = 1'b0; cmd_fill_i = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      check("t3_ready_idle_only", cmd_ready_o, !(busy_o || done_o));
      if (accepts.size() == n0 + 1) cmd_word_i = 4'h5;
      if (accepts.size() == n0 + 2) cmd_valid_i = 1'b0;
    end
    cmd_valid_i = 1'b0;
    check("t3_accepts", accepts.size() - n0, 2);
    if (accepts.size() >= n0 + 2) check("t3_accept_spacing", accepts[n0+1] - accepts[n0], 7);
    check("t3_ds", ds, 4'b0000);
    check("t3_queue_empty", exp_bits.size(), 0);

    // 4) abort during the 2nd SHIFT cycle
    d0 = done_cnt;
    cmd_valid_i = 1'b1; cmd_word_i = 4'b1011; cmd_dir_i = 1'b0; cmd_fill_i = 1'b0;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    tick();
    check("t4_in_shift2", funct_o, LEFT);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("t4_funct", funct_o, NA);
    check("t4_ready", cmd_ready_o, 1);
    check("t4_busy", busy_o, 0);
    check("t4_ds_partial", ds, 4'b1100);
    exp_bits.delete();
    tick();
    tick();
    check("t4_no_done", done_cnt - d0, 0);

    // 5) abort coincident with the last SHIFT cycle
    d0 = done_cnt;
    cmd_valid_i = 1'b1; cmd_word_i = 4'b1011; cmd_dir_i = 1'b1; cmd_fill_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    for (int i = 0; i < W; i++) tick();
    check("t5_last_shift", funct_o, RIGHT);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("t5_ready", cmd_ready_o, 1);
    check("t5_funct", funct_o, NA);
    check("t5_ds", ds, 4'b1111);
    check("t5_queue_empty", exp_bits.size(), 0);
    tick();
    check("t5_no_done", done_cnt - d0, 0);

    // 6) asynchronous reset mid-SHIFT, then a fresh command
    cmd_valid_i = 1'b1; cmd_word_i = 4'b0110; cmd_dir_i = 1'b0; cmd_fill_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    tick();
    check("t6_in_shift", busy_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    exp_bits.delete();
    #3;
    rst_n = 1'b1;
    d0 = done_cnt;
    tick();
    check("t6_idle_after_reset", cmd_ready_o, 1);
    cmd_valid_i = 1'b1; cmd_word_i = 4'b1001; cmd_dir_i = 1'b1; cmd_fill_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      cmd_valid_i = 1'b0;
    end
    check("t6_done_pulses", done_cnt - d0, 1);
    check("t6_ds", ds, 4'b0000);
    check("t6_queue_empty", exp_bits.size(), 0);
    check("t6_ready", cmd_ready_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_shift_seq
